// File: rtl/mem_emu_pkg.sv
// Shared types, default widths and sizing helpers for the memory-side emulation agent.
package mem_emu_pkg;

  localparam int unsigned MEM_EMU_DATA_W  = 512;
  localparam int unsigned MEM_EMU_ADDR_W  = 26;
  localparam int unsigned MEM_EMU_TAG_W   = 7;
  localparam int unsigned MEM_EMU_BE_W    = MEM_EMU_DATA_W / 8;
  localparam int unsigned MEM_EMU_LATENCY = 4;
  localparam int unsigned AGE_W           = $clog2(MEM_EMU_LATENCY + 1);

  typedef struct packed {
    logic                      rw;
    logic [MEM_EMU_BE_W-1:0]   byteen;
    logic [MEM_EMU_ADDR_W-1:0] addr;
    logic [MEM_EMU_DATA_W-1:0] data;
    logic [MEM_EMU_TAG_W-1:0]  tag;
  } mem_emu_req_t;

  typedef struct packed {
    logic [MEM_EMU_DATA_W-1:0] data;
    logic [MEM_EMU_TAG_W-1:0]  tag;
  } mem_emu_rsp_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned age_w(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_emu_rsp_queue.sv
// In-order read-response FIFO; every entry carries a saturating age so the top can tell when it is due.
module mem_emu_rsp_queue
  import mem_emu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned TAG_WIDTH  = 7,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic [TAG_WIDTH-1:0]          push_tag_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic                          pop_i,
  output logic [TAG_WIDTH-1:0]          head_tag_o,
  output logic [DATA_WIDTH-1:0]         head_data_o,
  output logic [TAG_WIDTH-1:0]          next_tag_o,
  output logic [DATA_WIDTH-1:0]         next_data_o,
  output logic                          head_due_o,
  output logic                          next_due_o,
  output logic [ptr_w(DEPTH):0]         count_next_o
);

  localparam int unsigned PTR_W    = ptr_w(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned AGE_BITS = age_w(LATENCY);

  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [AGE_BITS-1:0]   age_q  [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q, nxt_ptr_c;
  logic [CNT_W-1:0]      count_q;

  assign nxt_ptr_c   = rd_ptr_q + PTR_W'(1);
  assign head_tag_o  = tag_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign next_tag_o  = tag_q[nxt_ptr_c];
  assign next_data_o = data_q[nxt_ptr_c];

  // "Due" means the entry reaches LATENCY at the coming edge (or already has).
  assign head_due_o = (count_q != '0) && (age_q[rd_ptr_q] >= AGE_BITS'(LATENCY - 1));
  assign next_due_o = (count_q >= CNT_W'(2)) && (age_q[nxt_ptr_c] >= AGE_BITS'(LATENCY - 1));

  always_comb begin
    count_next_o = count_q;
    if (push_i && !pop_i) begin
      count_next_o = count_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_next_o = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      tag_q[wr_ptr_q]  <= push_tag_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= nxt_ptr_c;
      count_q <= count_next_o;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push_i && (wr_ptr_q == PTR_W'(i))) begin
          age_q[i] <= '0;
        end else if (age_q[i] < AGE_BITS'(LATENCY)) begin
          age_q[i] <= age_q[i] + AGE_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mem_emu_agent.sv
// Memory-side agent: byte-enabled line array with fixed-latency, in-order tagged read responses.
// Optional periodic request backpressure when MEM_EMU_STALL_EN is defined.
module mem_emu_agent
  import mem_emu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned TAG_WIDTH   = 7,
  parameter int unsigned MEM_LOG2    = 10,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned STALL_ON    = 2,
  parameter int unsigned STALL_OFF   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned LINES = 2 ** MEM_LOG2;
  localparam int unsigned CNT_W = ptr_w(QUEUE_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem_q [LINES];
  logic [MEM_LOG2-1:0]   idx_c;
  logic                  wr_fire_c, rd_fire_c, pop_c, open_c;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d, head_data_c, next_data_c;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d, head_tag_c, next_tag_c;
  logic                  head_due_c, next_due_c;
  logic [CNT_W-1:0]      count_next_c;
  logic                  unused_addr_c;

  assign idx_c         = mem_req_addr[MEM_LOG2-1:0];
  assign unused_addr_c = ^mem_req_addr[ADDR_WIDTH-1:MEM_LOG2];
  assign wr_fire_c     = mem_req_valid && ready_q && mem_req_rw;
  assign rd_fire_c     = mem_req_valid && ready_q && !mem_req_rw;
  assign pop_c         = rsp_valid_q && mem_rsp_ready;

  assign mem_req_ready = ready_q;
  assign mem_rsp_valid = rsp_valid_q;
  assign mem_rsp_data  = rsp_data_q;
  assign mem_rsp_tag   = rsp_tag_q;

  // Byte-merge write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (mem_req_byteen[b]) mem_q[idx_c][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  mem_emu_rsp_queue #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .DEPTH      (QUEUE_DEPTH),
    .LATENCY    (LATENCY)
  ) u_rsp_queue (
    .clk_i        (clk),
    .reset_i      (reset),
    .push_i       (rd_fire_c),
    .push_tag_i   (mem_req_tag),
    .push_data_i  (mem_q[idx_c]),
    .pop_i        (pop_c),
    .head_tag_o   (head_tag_c),
    .head_data_o  (head_data_c),
    .next_tag_o   (next_tag_c),
    .next_data_o  (next_data_c),
    .head_due_o   (head_due_c),
    .next_due_o   (next_due_c),
    .count_next_o (count_next_c)
  );

`ifdef MEM_EMU_STALL_EN
  localparam int unsigned PERIOD = STALL_ON + STALL_OFF;
  localparam int unsigned PH_W   = ptr_w(PERIOD);
  logic [PH_W-1:0] phase_q, phase_d;

  assign open_c  = phase_q < PH_W'(STALL_ON);
  assign phase_d = (phase_q == PH_W'(PERIOD - 1)) ? '0 : phase_q + PH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end
`else
  logic unused_stall_c;
  assign unused_stall_c = (STALL_ON + STALL_OFF) == 0;
  assign open_c         = 1'b1;
`endif

  // Output stage tracks the queue head; on a pop it advances straight to the next entry if due.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    ready_d     = (count_next_c < CNT_W'(QUEUE_DEPTH)) && open_c;
    if (pop_c) begin
      rsp_valid_d = next_due_c;
      if (next_due_c) begin
        rsp_data_d = next_data_c;
        rsp_tag_d  = next_tag_c;
      end
    end else if (!rsp_valid_q && head_due_c) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = head_data_c;
      rsp_tag_d   = head_tag_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

endmodule
